mem_data_hs: RTL and testbench
==============================

Name: mem_data_hs

Overview:
- Parametrised byte-addressed data memory for the RV32 data path.
- Adds a req/ready/done handshake with configurable wait states, so it serves both the multi-cycle core and a stalled single-cycle core.
- Supports byte, half and word loads/stores, little-endian, with sign/zero extension on loads.
- Flags misaligned and out-of-range accesses instead of corrupting memory.

Parameters:
- DEPTH_BYTES, 256, memory size in bytes; power of two, >= 16.
- WAIT_CYCLES, 1, extra wait states between acceptance and completion; 0..15.
- WATCH_ADDR, 32'h30, byte address of the watched word; word-aligned, <= DEPTH_BYTES-4.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_clk_enable  in  1  global stall; low freezes all state.
- i_req  in  1  access request.
- i_we  in  1  1 = store, 0 = load.
- i_size  in  2  00 byte, 01 half, 10 word; 11 is treated as a fault.
- i_unsigned  in  1  load zero-extends when set; ignored for word and for stores.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data; right-aligned bytes used.
- o_ready  out  1  block can accept a request.
- o_done  out  1  one-cycle completion pulse, for loads and stores.
- o_rdata  out  32  load result; valid while o_done=1 and the access was a load.
- o_fault  out  1  completed access was misaligned, out of range or used size 11; valid with o_done.
- o_watch_word  out  32  present only with MEM_DATA_WATCH_EN.
- o_watch_hit  out  1  present only with MEM_DATA_WATCH_EN.

Behaviour:
- Reset (async assert of i_rst_n):
  - FSM goes to IDLE; wait counter = 0.
  - o_done = 0, o_fault = 0, o_rdata = 0, o_watch_hit = 0; o_ready = 1 since it is decoded from IDLE.
  - Memory array is NOT cleared; its contents are undefined until written.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: o_ready = 1. If i_req & i_clk_enable, capture addr/size/we/unsigned/wdata and evaluate fault. Go to WAIT with counter = WAIT_CYCLES if WAIT_CYCLES > 0, otherwise go straight to DONE.
  - WAIT: decrement the counter each enabled cycle. When the counter reaches 1, go to DONE.
  - DONE: exactly one cycle with o_done = 1, o_ready = 0, then go to IDLE.
- Access timing:
  - The store write and the load data register both happen on the clock edge that enters DONE.
  - Latency: request accepted at edge E; o_done is high in the cycle after edge E+WAIT_CYCLES.
  - Throughput: one access per WAIT_CYCLES+2 cycles.
- i_clk_enable low: state, counter, o_rdata and o_fault hold. If it goes low while in DONE, o_done stays high until the next enabled edge.
- Byte ordering: little-endian; byte at address A goes to rdata[7:0], A+1 to [15:8], and so on.
- Load extension:
  - lb/lh: sign-extend from bit 7/15.
  - lbu/lhu: zero-extend.
  - Word: no extension.
- Stores: write only the addressed 1, 2 or 4 bytes; all other bytes are untouched.
- Fault conditions (any one sets it):
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size = 11;
  - addr + size_bytes > DEPTH_BYTES (the full 32-bit address is compared).
- On fault: no write, o_rdata = 0, o_fault = 1 in the DONE cycle. o_fault clears on the next acceptance.
- i_req while not IDLE: ignored, not queued. The requester must hold i_req until it sees o_ready & its edge.
- Reset mid-operation: the pending access is dropped and a store in WAIT is never written.

Optional Feature:
- Macro: MEM_DATA_WATCH_EN.
- When defined:
  - o_watch_word is a combinational view of bytes WATCH_ADDR..+3, little-endian.
  - o_watch_hit is registered and pulses with o_done when a non-faulting store writes any byte of the watched word.
  - Reset value of o_watch_hit is 0.
- When undefined: both ports and the logic behind them are absent; everything else is unchanged.

Test Plan:
- Extension: sw 0x10 = 0x8081F0F1 -> lb 0x10 = 0xFFFFFFF1; lbu 0x13 = 0x00000080; lh 0x12 = 0xFFFF8081; lhu 0x10 = 0x0000F0F1; o_fault = 0 throughout.
- Partial stores: sw 0x20 = 0; sb 0x21 wdata 0xFFFFFFAB -> lw 0x20 = 0x0000AB00; then sh 0x22 wdata 0x00001234 -> lw 0x20 = 0x1234AB00.
- Faults:
  - Setup: sw 0x10 = 0x55667788.
  - lw 0x11 -> o_fault = 1, o_rdata = 0.
  - sh 0x13 wdata 0xFFFF -> o_fault = 1, and a subsequent lw 0x10 still returns 0x55667788.
  - lw DEPTH_BYTES-2 -> o_fault = 1.
- Latency/stall (WAIT_CYCLES = 3):
  - Accept at edge 0 -> o_ready low cycles 1..4; o_done high only in the cycle after edge 3.
  - Hold i_clk_enable low for 2 cycles in WAIT -> o_done is delayed by exactly 2 cycles.
- Async reset: sw 0x40 = 0x11223344; start sw 0x40 = 0xDEADBEEF and pull i_rst_n low during WAIT -> outputs go to reset values immediately; after release, lw 0x40 = 0x11223344.
- Watch (macro on, WATCH_ADDR = 0x30):
  - sw 0x30 = 0xCAFEBABE -> o_watch_word = 0xCAFEBABE, o_watch_hit pulses with o_done.
  - sb 0x33 wdata 0x12 -> o_watch_word = 0x12FEBABE, hit pulses.
  - sb 0x34 -> no hit.

Source files
------------

// File: rtl/mem_data_hs.sv
// mem_data_hs: byte-addressed RV32 data memory with a req/ready/done handshake.
// Byte, half and word accesses are little-endian. Loads can be sign- or zero-extended.
// WAIT_CYCLES extra wait states are inserted between acceptance and completion.
// Misaligned, out-of-range and size-11 accesses are reported on o_fault and never write.
// Optional feature macro: MEM_DATA_WATCH_EN. It adds o_watch_word and o_watch_hit
// for the word at WATCH_ADDR.
module mem_data_hs #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] WATCH_ADDR  = 32'h30
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clk_enable,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_fault
`ifdef MEM_DATA_WATCH_EN
    ,
    output logic [31:0] o_watch_word,
    output logic        o_watch_hit
`endif
);

    localparam int          AW        = $clog2(DEPTH_BYTES);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [32:0] LIMIT     = 33'(DEPTH_BYTES);

    // Reject parameter sets the address decode cannot honour.
    if (DEPTH_BYTES < 16 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
        $error("mem_data_hs: DEPTH_BYTES must be a power of two >= 16");
    end
    if (WATCH_ADDR[1:0] != 2'b00 || WATCH_ADDR > DEPTH_BYTES - 4) begin : g_bad_watch
        $error("mem_data_hs: WATCH_ADDR must be word aligned and inside the memory");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic [3:0]  next_cnt;
    logic        accept;
    logic        enter_done;

    logic [7:0]  mem [DEPTH_BYTES];

    // Request fields captured at acceptance and held until completion.
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;

    // Fields of the access being completed. In IDLE they come straight from the
    // inputs, so that WAIT_CYCLES = 0 can complete on the accepting edge.
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic [1:0]  eff_size;
    logic        eff_we;
    logic        eff_uns;
    logic        eff_fault;

    logic [AW-1:0] idx0;
    logic [AW-1:0] idx1;
    logic [AW-1:0] idx2;
    logic [AW-1:0] idx3;
    logic [31:0]   raw;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // The range check uses a 33-bit sum so that addresses near 2^32 cannot wrap into range.
    function automatic logic access_fault(input logic [1:0] size, input logic [31:0] addr);
        logic misaligned;
        logic out_of_range;
        misaligned   = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        out_of_range = ({1'b0, addr} + {30'b0, size_bytes(size)}) > LIMIT;
        return (size == 2'b11) || misaligned || out_of_range;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                                input logic [31:0] word);
        case (size)
            2'b00:   return {{24{~uns & word[7]}}, word[7:0]};
            2'b01:   return {{16{~uns & word[15]}}, word[15:0]};
            default: return word;
        endcase
    endfunction

    assign o_ready = (state == S_IDLE);
    assign o_done  = (state == S_DONE);

    assign eff_addr  = (state == S_IDLE) ? i_addr     : addr_q;
    assign eff_wdata = (state == S_IDLE) ? i_wdata    : wdata_q;
    assign eff_size  = (state == S_IDLE) ? i_size     : size_q;
    assign eff_we    = (state == S_IDLE) ? i_we       : we_q;
    assign eff_uns   = (state == S_IDLE) ? i_unsigned : uns_q;
    assign eff_fault = access_fault(eff_size, eff_addr);

    assign idx0 = eff_addr[AW-1:0];
    assign idx1 = idx0 + AW'(1);
    assign idx2 = idx0 + AW'(2);
    assign idx3 = idx0 + AW'(3);
    assign raw  = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};

    assign enter_done = i_clk_enable && (next_state == S_DONE);

    // FSM state and wait counter; everything holds while the clock enable is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else if (i_clk_enable) begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic: IDLE accepts, WAIT counts down, DONE lasts exactly one enabled cycle.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        next_state = S_WAIT;
                        next_cnt   = WAIT_INIT;
                    end else begin
                        next_state = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    next_state = S_DONE;
                    next_cnt   = 4'd0;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Capture the request on acceptance. This is datapath only, so it has no reset.
    always_ff @(posedge i_clk) begin
        if (i_clk_enable && accept) begin
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            size_q  <= i_size;
            we_q    <= i_we;
            uns_q   <= i_unsigned;
        end
    end

    // Result registers: loaded on the edge entering DONE; o_fault clears on a new acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata <= 32'd0;
            o_fault <= 1'b0;
        end else if (enter_done) begin
            o_fault <= eff_fault;
            o_rdata <= (eff_fault || eff_we) ? 32'd0 : load_extend(eff_size, eff_uns, raw);
        end else if (i_clk_enable && accept) begin
            o_fault <= 1'b0;
        end
    end

    // Store path: write only the addressed bytes, and only for a non-faulting store.
    always_ff @(posedge i_clk) begin
        if (enter_done && eff_we && !eff_fault) begin
            mem[idx0] <= eff_wdata[7:0];
            if (eff_size != 2'b00) begin
                mem[idx1] <= eff_wdata[15:8];
            end
            if (eff_size == 2'b10) begin
                mem[idx2] <= eff_wdata[23:16];
                mem[idx3] <= eff_wdata[31:24];
            end
        end
    end

`ifdef MEM_DATA_WATCH_EN
    localparam logic [AW-1:0] WA = WATCH_ADDR[AW-1:0];

    logic watch_overlap;

    assign o_watch_word  = {mem[WA + AW'(3)], mem[WA + AW'(2)], mem[WA + AW'(1)], mem[WA]};
    assign watch_overlap = (eff_addr <= WATCH_ADDR + 32'd3) &&
                           (eff_addr + {29'b0, size_bytes(eff_size)} > WATCH_ADDR);

    // Hit pulse is aligned with o_done: set on entering DONE, cleared on the next enabled edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_watch_hit <= 1'b0;
        end else if (i_clk_enable) begin
            o_watch_hit <= (next_state == S_DONE) && eff_we && !eff_fault && watch_overlap;
        end
    end
`endif

endmodule

// File: tb/tb_mem_data_hs.sv
// Self-checking bench for mem_data_hs. A driver issues accesses and pushes the
// expected response, which comes from a byte-array reference model. A monitor pops
// and compares on every new o_done pulse.
module tb_mem_data_hs;

    localparam int          DEPTH = 256;
    localparam int          WAITC = 3;
    localparam logic [31:0] WATCH = 32'h30;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_clk_enable;
    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_fault;
`ifdef MEM_DATA_WATCH_EN
    logic [31:0] o_watch_word;
    logic        o_watch_hit;
`endif

    mem_data_hs #(
        .DEPTH_BYTES (DEPTH),
        .WAIT_CYCLES (WAITC),
        .WATCH_ADDR  (WATCH)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clk_enable (i_clk_enable),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_size       (i_size),
        .i_unsigned   (i_unsigned),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_ready      (o_ready),
        .o_done       (o_done),
        .o_rdata      (o_rdata),
        .o_fault      (o_fault)
`ifdef MEM_DATA_WATCH_EN
        ,
        .o_watch_word (o_watch_word),
        .o_watch_hit  (o_watch_hit)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic        fault;
        logic [31:0] rdata;
        logic        hit;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [DEPTH];
    int         checks = 0;
    int         errors = 0;
    logic       prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Reference model. It applies the access rules to a plain byte array and
    // returns the response the DUT must give.
    task automatic predict(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
        int     n;
        longint a;
        longint val;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        a = {32'b0, addr};
        e.we    = we;
        e.rdata = 32'd0;
        e.hit   = 1'b0;
        if (n == 0) e.fault = 1'b1;
        else        e.fault = (a % n != 0) || (a + n > DEPTH);
        if (!e.fault) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wdata[8*i +: 8];
                e.hit = (a <= longint'(WATCH) + 3) && (a + n - 1 >= longint'(WATCH));
            end else begin
                val = 0;
                for (int i = 0; i < n; i++) val += longint'(ref_mem[int'(a) + i]) << (8 * i);
                if (!uns && n < 4 && val >= (longint'(1) << (8 * n - 1)))
                    val -= (longint'(1) << (8 * n));
                e.rdata = val[31:0];
            end
        end
    endtask

    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   n;
        predict(we, size, uns, addr, wdata, e);
        sb.push_back(e);
        @(negedge i_clk);
        i_req = 1'b1; i_we = we; i_size = size; i_unsigned = uns; i_addr = addr; i_wdata = wdata;
        n = 0;
        while (!o_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: o_ready=%0b after %0d cycles, want 1", o_ready, n);
        end
        @(posedge i_clk);
        #1 i_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !o_ready) && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (sb.size() != 0 || !o_ready) begin
            checks++; errors++;
            $display("FAIL idle_timeout: %0d responses outstanding, want 0", sb.size());
        end
    endtask

    // Monitor: compare each new completion against the oldest expected response.
    always @(negedge i_clk) begin
        exp_t me;
        if (o_done && !prev_done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got o_done=1 with empty scoreboard, want 0");
            end else begin
                me = sb.pop_front();
                check("done_fault", {31'b0, o_fault}, {31'b0, me.fault});
                if (!me.we) check("done_rdata", o_rdata, me.rdata);
`ifdef MEM_DATA_WATCH_EN
                check("done_watch_hit", {31'b0, o_watch_hit}, {31'b0, me.hit});
`endif
            end
        end
        prev_done = o_done;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad;
        int          r;
        i_rst_n = 1'b0; i_clk_enable = 1'b1; i_req = 1'b0; i_we = 1'b0;
        i_size = 2'd0; i_unsigned = 1'b0; i_addr = 32'd0; i_wdata = 32'd0;
        #1;
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_done",  {31'b0, o_done},  32'd0);
        check("rst_fault", {31'b0, o_fault}, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // Give every byte a known value so that random loads are fully predictable.
        for (int a = 0; a < DEPTH; a += 4) access(1'b1, 2'd2, 1'b0, a, $urandom);

        // Sign and zero extension
        access(1, 2'd2, 0, 32'h10, 32'h8081F0F1);
        access(0, 2'd0, 0, 32'h10, 0);
        access(0, 2'd0, 1, 32'h13, 0);
        access(0, 2'd1, 0, 32'h12, 0);
        access(0, 2'd1, 1, 32'h10, 0);

        // Partial stores
        access(1, 2'd2, 0, 32'h20, 32'h0);
        access(1, 2'd0, 0, 32'h21, 32'hFFFFFFAB);
        access(0, 2'd2, 0, 32'h20, 0);
        access(1, 2'd1, 0, 32'h22, 32'h00001234);
        access(0, 2'd2, 0, 32'h20, 0);

        // Faults
        access(1, 2'd2, 0, 32'h10, 32'h55667788);
        access(0, 2'd2, 0, 32'h11, 0);
        access(1, 2'd1, 0, 32'h13, 32'h0000FFFF);
        access(0, 2'd2, 0, 32'h10, 0);
        access(0, 2'd2, 0, DEPTH - 2, 0);
        access(0, 2'd3, 0, 32'h10, 0);
        access(0, 2'd2, 0, 32'hFFFFFFFC, 0);
        access(0, 2'd0, 0, DEPTH, 0);
        access(0, 2'd0, 1, DEPTH - 1, 0);
        access(0, 2'd2, 0, DEPTH - 4, 0);
        wait_idle();

        // Latency: ready is low in cycles 1..4 and done is high only in cycle 4.
        access(0, 2'd2, 0, 32'h10, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge i_clk);
            check($sformatf("lat_ready_c%0d", k), {31'b0, o_ready}, 32'(k == 5));
            check($sformatf("lat_done_c%0d", k),  {31'b0, o_done},  32'(k == 4));
        end

        // A two-cycle enable drop in WAIT delays done by exactly two cycles.
        access(0, 2'd1, 0, 32'h12, 0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge i_clk);
            check($sformatf("stallw_done_c%0d", k),  {31'b0, o_done},  32'(k == 6));
            check($sformatf("stallw_ready_c%0d", k), {31'b0, o_ready}, 32'(k == 7));
            if (k == 1) i_clk_enable = 1'b0;
            if (k == 3) i_clk_enable = 1'b1;
        end

        // An enable drop in DONE keeps done high until the next enabled edge.
        access(0, 2'd0, 1, 32'h11, 0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge i_clk);
            check($sformatf("stalld_done_c%0d", k), {31'b0, o_done}, 32'(k >= 4 && k <= 6));
            if (k == 4) i_clk_enable = 1'b0;
            if (k == 6) i_clk_enable = 1'b1;
        end
        wait_idle();

        // Asynchronous reset in the middle of a store
        access(1, 2'd2, 0, 32'h40, 32'h11223344);
        access(0, 2'd2, 0, 32'h40, 0);
        wait_idle();
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_size = 2'd2; i_addr = 32'h40; i_wdata = 32'hDEADBEEF;
        @(posedge i_clk);
        #1 i_req = 1'b0;
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_ready", {31'b0, o_ready}, 32'd1);
        check("arst_done",  {31'b0, o_done},  32'd0);
        check("arst_fault", {31'b0, o_fault}, 32'd0);
        check("arst_rdata", o_rdata, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        access(0, 2'd2, 0, 32'h40, 0);
        wait_idle();

`ifdef MEM_DATA_WATCH_EN
        access(1, 2'd2, 0, 32'h30, 32'hCAFEBABE);
        wait_idle();
        check("watch_word_sw", o_watch_word, 32'hCAFEBABE);
        access(1, 2'd0, 0, 32'h33, 32'h12);
        wait_idle();
        check("watch_word_sb", o_watch_word, 32'h12FEBABE);
        access(1, 2'd0, 0, 32'h34, 32'h77);
        wait_idle();
`endif

        // Randomized accesses against the reference model
        for (int t = 0; t < 300; t++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r  = $urandom_range(0, 9);
            if (r == 0)      ad = $urandom;
            else if (r == 1) ad = DEPTH - $urandom_range(0, 4);
            else             ad = $urandom_range(0, DEPTH - 1);
            if (r >= 3 && r < 8) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 4)) @(negedge i_clk);
        end
        wait_idle();
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
